// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the multiplexed 7-segment display path.
//   - 7-segment patterns (active-high, bit order {g,f,e,d,c,b,a})
//   - SEG_OFF and the decimal-point bit position in the 8-bit segment bus
//   - digit slot indices (seconds units .. hours tens)
//   - mode encoding for set-time
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;   // segment g only
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam int DP_BIT = 7;                 // seg = {dp,g,f,e,d,c,b,a}

    localparam logic [2:0] IDX_SEC_LO = 3'd0;
    localparam logic [2:0] IDX_SEC_HI = 3'd1;
    localparam logic [2:0] IDX_MIN_LO = 3'd2;
    localparam logic [2:0] IDX_MIN_HI = 3'd3;
    localparam logic [2:0] IDX_HR_LO  = 3'd4;
    localparam logic [2:0] IDX_HR_HI  = 3'd5;

    localparam logic [1:0] MODE_SET = 2'b10;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } blink_phase_t;

    // Frame-coherent copy of everything the display consumes.
    typedef struct packed {
        logic [5:0][3:0] dig;        // dig[0] = seconds units .. dig[5] = hours tens
        logic [1:0]      mode;
        logic            fsel_hours; // 1 = hours field selected for adjust
    } snap_t;

    // True when the slot belongs to the field currently being adjusted.
    function automatic logic in_set_field(input logic [2:0] idx, input logic hours);
        if (hours) begin
            return (idx == IDX_HR_LO) || (idx == IDX_HR_HI);
        end
        return (idx == IDX_MIN_LO) || (idx == IDX_MIN_HI);
    endfunction

    // dp marks the hh.mm.ss separators: after the minutes and hours units digits.
    function automatic logic dp_on(input logic [2:0] idx);
        return (idx == IDX_MIN_LO) || (idx == IDX_HR_LO);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to 7-segment encoder, active-high output.
//   i_bcd  in  4  digit value; 10..15 render as a dash
//   o_seg  out 7  {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;  // out-of-range digits (e.g. transient 10)
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
// Time-multiplexes six BCD clock digits onto one shared segment bus.
// Each digit owns a slot of SCAN_DIV cycles; the first DEAD_CYC cycles of a
// slot drive everything inactive to prevent ghosting. The digit set, mode and
// field select are snapshotted once per frame so a frame never mixes old and
// new values. In set-time mode the selected field blinks at BLINK_HZ.
//
// Ports
//   clk      in   1  system clock
//   rst      in   1  synchronous active-high reset
//   a..f     in   4  sec units, sec tens, min units, min tens, hr units, hr tens
//   mk       in   2  mode (2'b10 = set time)
//   k1       in   2  field select, bit0: 0 = minutes, 1 = hours
//   seg      out  8  {dp,g,f,e,d,c,b,a}
//   dig_sel  out  6  one-hot digit enable, bit0 = a .. bit5 = f
//
// Blink phase
//   state      | meaning
//   PH_VISIBLE | selected field shown normally
//   PH_HIDDEN  | selected field segments a-g blanked (set mode only)
// -----------------------------------------------------------------------------
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2,
    parameter int DEAD_CYC = 16,
    parameter bit ACT_LOW  = 1'b1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic [3:0] e,
    input  logic [3:0] f,
    input  logic [1:0] mk,
    input  logic [1:0] k1,
    output logic [7:0] seg,
    output logic [5:0] dig_sel
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int PRESC_W   = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [31:0]        DEAD_U     = 32'(DEAD_CYC);

    localparam logic [7:0] SEG_IDLE = ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [5:0] DIG_IDLE = ACT_LOW ? 6'h3F : 6'h00;

    logic [PRESC_W-1:0] r_presc;
    logic [2:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    blink_phase_t       r_phase;
    snap_t              r_snap;
    logic               r_first;
    logic [7:0]         r_seg;
    logic [5:0]         r_dig;

    logic               w_presc_wrap;
    logic               w_blink_wrap;
    logic               w_frame_wrap;
    logic [2:0]         w_idx;
    logic [3:0]         w_digit;
    logic [6:0]         w_pat;
    logic               w_blank;
    logic               w_dead;
    logic [7:0]         w_seg_ah;
    logic [5:0]         w_dig_ah;
    logic               w_unused_k1;

    // Only k1[0] carries meaning for the display.
    assign w_unused_k1 = k1[1];

    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    assign w_frame_wrap = w_presc_wrap && (r_idx == IDX_HR_HI);

    // Unreachable indices 6/7 display as slot 0 until the counter is repaired.
    assign w_idx = (r_idx > IDX_HR_HI) ? IDX_SEC_LO : r_idx;

    always_comb begin
        w_digit = r_snap.dig[0];
        case (w_idx)
            IDX_SEC_LO: w_digit = r_snap.dig[0];
            IDX_SEC_HI: w_digit = r_snap.dig[1];
            IDX_MIN_LO: w_digit = r_snap.dig[2];
            IDX_MIN_HI: w_digit = r_snap.dig[3];
            IDX_HR_LO:  w_digit = r_snap.dig[4];
            IDX_HR_HI:  w_digit = r_snap.dig[5];
            default:    w_digit = r_snap.dig[0];
        endcase
    end

    bcd_to_seg7 u_enc (
        .i_bcd (w_digit),
        .o_seg (w_pat)
    );

    assign w_blank = (r_snap.mode == MODE_SET) &&
                     (r_phase == PH_HIDDEN) &&
                     in_set_field(w_idx, r_snap.fsel_hours);

    assign w_dead = ({{(32 - PRESC_W){1'b0}}, r_presc} < DEAD_U);

    // Blanking removes a-g only; dp and the digit enable stay on.
    always_comb begin
        w_seg_ah         = {1'b0, (w_blank ? SEG_OFF : w_pat)};
        w_seg_ah[DP_BIT] = dp_on(w_idx);
    end

    assign w_dig_ah = 6'b000001 << w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= IDX_SEC_LO;
            r_blink_cnt <= '0;
            r_phase     <= PH_VISIBLE;
            r_snap      <= '0;
            r_first     <= 1'b1;
            r_seg       <= SEG_IDLE;
            r_dig       <= DIG_IDLE;
        end else begin
            r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;

            if (w_presc_wrap) begin
                r_idx <= (r_idx >= IDX_HR_HI) ? IDX_SEC_LO : r_idx + 3'd1;
            end else if (r_idx > IDX_HR_HI) begin
                r_idx <= IDX_SEC_LO;
            end

            // Free-running; independent of slot timing and mode changes.
            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            if (w_blink_wrap) begin
                r_phase <= (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end

            if (r_first || w_frame_wrap) begin
                r_snap.dig        <= {f, e, d, c, b, a};
                r_snap.mode       <= mk;
                r_snap.fsel_hours <= k1[0];
            end
            r_first <= 1'b0;

            if (w_dead) begin
                r_seg <= SEG_IDLE;
                r_dig <= DIG_IDLE;
            end else begin
                r_seg <= ACT_LOW ? ~w_seg_ah : w_seg_ah;
                r_dig <= ACT_LOW ? ~w_dig_ah : w_dig_ah;
            end
        end
    end

    assign seg     = r_seg;
    assign dig_sel = r_dig;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b, c, d, e, f;
    logic [1:0] mk, k1;
    logic [7:0] seg;
    logic [5:0] dig_sel;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .CLK_HZ   (1200),
        .SCAN_HZ  (100),
        .BLINK_HZ (1),
        .DEAD_CYC (2),
        .ACT_LOW  (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .mk      (mk),
        .k1      (k1),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    typedef struct packed {
        logic [7:0] seg;
        logic [5:0] dig;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         k;        // index of the next edge since reset release
    int         last_k;   // index of the edge whose output is on the pins
    logic [3:0] s_dig[6];
    logic [1:0] s_mk;
    logic [1:0] s_k1;

    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected pins after edge kk: slot = kk/12, 2 dead cycles, blink half-period 600.
    function automatic exp_t model(input int kk);
        int         p;
        int         idx;
        logic       blank;
        logic [7:0] sa;
        exp_t       r;
        p   = kk % 12;
        idx = (kk / 12) % 6;
        if (p < 2) begin
            r.seg = 8'hFF;
            r.dig = 6'h3F;
        end else begin
            blank = (s_mk == 2'b10) && (((kk / 600) % 2) == 1) &&
                    (s_k1[0] ? (idx >= 4) : (idx == 2 || idx == 3));
            sa    = {(idx == 2 || idx == 4), (blank ? 7'h00 : pat(s_dig[idx]))};
            r.seg = ~sa;
            r.dig = ~(6'(1) << idx);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, last_k, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t ex;
        if (rst) begin
            ex.seg = 8'hFF;
            ex.dig = 6'h3F;
        end else begin
            ex = model(k);
            if (k == 0 || (k % 72) == 71) begin
                s_dig = '{a, b, c, d, e, f};
                s_mk  = mk;
                s_k1  = k1;
            end
        end
        q.push_back(ex);
        @(posedge clk);
        #1;
        last_k = rst ? -1 : k;
        k      = rst ? 0 : k + 1;
        ex = q.pop_front();
        chk("seg", seg, ex.seg);
        chk("dig_sel", {2'b00, dig_sel}, {2'b00, ex.dig});
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (last_k != target && guard < 5000) begin
            tick();
            guard++;
        end
        if (last_k != target) begin
            n_cmp++;
            n_err++;
            $error("FAIL run_to observed=%0d expected=%0d", last_k, target);
        end
    endtask

    initial begin
        rst = 1'b1;
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4; e = 4'd5; f = 4'd6;
        mk = 2'b00; k1 = 2'b00;
        k = 0; last_k = -1;
        s_dig = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        s_mk = 2'b00; s_k1 = 2'b00;

        repeat (3) tick();
        chk("rst_seg", seg, 8'hFF);
        chk("rst_dig", {2'b00, dig_sel}, 8'h3F);
        rst = 1'b0;

        // slot 0 shows '1' from prescaler 2..11
        run_to(1);  chk("dead_dig", {2'b00, dig_sel}, 8'h3F);
        run_to(3);  chk("slot0_seg", seg, 8'hF9);
                    chk("slot0_dig", {2'b00, dig_sel}, 8'h3E);
        run_to(11); chk("slot0_end_seg", seg, 8'hF9);
        run_to(12); chk("slot1_dead_dig", {2'b00, dig_sel}, 8'h3F);
        run_to(75); chk("frame1_slot0_seg", seg, 8'hF9);

        // mid-frame changes stay invisible until the next frame
        run_to(146); b = 4'd9;
        run_to(159); chk("snap_b_old", seg, 8'hA4);
        run_to(180); a = 4'd7;
        run_to(219); chk("snap_a_new", seg, 8'hF8);
        run_to(231); chk("snap_b_new", seg, 8'h90);

        // out-of-range digit renders as dash; dp on minutes units
        run_to(290); c = 4'hA; f = 4'd9;
        run_to(389); chk("dash_seg", seg, 8'h3F);
                     chk("dash_dig", {2'b00, dig_sel}, 8'h3B);
        run_to(425); chk("hr_hi_seg", seg, 8'h90);
                     chk("hr_hi_dig", {2'b00, dig_sel}, 8'h1F);

        // set mode, hours selected: hidden phase spans edges 600..1199
        run_to(430); mk = 2'b10; k1 = 2'b01;
        run_to(677); chk("min_not_blank", seg, 8'h3F);
        run_to(701); chk("hr_lo_blank_seg", seg, 8'h7F);
                     chk("hr_lo_blank_dig", {2'b00, dig_sel}, 8'h2F);
        run_to(713); chk("hr_hi_blank_seg", seg, 8'hFF);
                     chk("hr_hi_blank_dig", {2'b00, dig_sel}, 8'h1F);
        run_to(1277); chk("hr_lo_visible", seg, 8'h12);

        // reset during slot 4
        run_to(1350);
        rst = 1'b1;
        tick();
        chk("rst_mid_seg", seg, 8'hFF);
        chk("rst_mid_dig", {2'b00, dig_sel}, 8'h3F);
        tick();
        rst = 1'b0;
        run_to(3);  chk("post_rst_slot0", seg, 8'hF8);
        run_to(53); chk("post_rst_phase_visible", seg, 8'h12);
        run_to(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
